// File: rtl/mem_bus_responder.sv
// Word-array responder for the 32-bit cache memory bus: accepts one word request at a time
// and answers after a fixed LATENCY with a one-cycle mem_data_valid pulse.
module mem_bus_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd_wr,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        mem_data_oe,
  output logic        mem_data_valid,
  output logic        resp_busy
);

  localparam int unsigned Words = 1 << ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic                   wr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            mem_q [Words];

  logic [ADDR_BITS-1:0]   req_idx;
  logic                   accept;
  logic                   unused_addr;

  assign req_idx     = mem_addr[ADDR_BITS+1:2];
  assign accept      = (state_q == StIdle) && mem_en && mem_req;
  assign unused_addr = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};

  // All bus outputs are registered; they are set on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      idx_q          <= '0;
      wr_q           <= 1'b0;
      wdata_q        <= '0;
      mem_data_out   <= '0;
      mem_data_oe    <= 1'b0;
      mem_data_valid <= 1'b0;
      resp_busy      <= 1'b0;
    end else begin
      mem_data_valid <= 1'b0;
      mem_data_oe    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q     <= req_idx;
            wr_q      <= mem_rd_wr;
            wdata_q   <= mem_data_in;
            cnt_q     <= 4'(LATENCY - 1);
            resp_busy <= 1'b1;
            if (LATENCY == 1) begin
              state_q        <= StResp;
              mem_data_valid <= 1'b1;
              mem_data_oe    <= ~mem_rd_wr;
              if (!mem_rd_wr) mem_data_out <= mem_q[req_idx];
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q        <= StResp;
            mem_data_valid <= 1'b1;
            mem_data_oe    <= ~wr_q;
            if (!wr_q) mem_data_out <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          resp_busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write commits on the edge leaving RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StResp) && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: instance A with LATENCY=4, instance B with LATENCY=1
// sharing the bus inputs but with separate mem_en.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_a, en_b, req, rdwr;
  logic [31:0] addr, din;
  logic [31:0] a_dout, b_dout;
  logic        a_oe, a_valid, a_busy, b_oe, b_valid, b_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder #(.ADDR_BITS(10), .LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .mem_en(en_a), .mem_req(req), .mem_addr(addr),
    .mem_rd_wr(rdwr), .mem_data_in(din), .mem_data_out(a_dout), .mem_data_oe(a_oe),
    .mem_data_valid(a_valid), .resp_busy(a_busy)
  );

  mem_bus_responder #(.ADDR_BITS(10), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .mem_en(en_b), .mem_req(req), .mem_addr(addr),
    .mem_rd_wr(rdwr), .mem_data_in(din), .mem_data_out(b_dout), .mem_data_oe(b_oe),
    .mem_data_valid(b_valid), .resp_busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit b, input logic rw, input logic [31:0] a, input logic [31:0] d);
    en_a = ~b; en_b = b; req = 1'b1; rdwr = rw; addr = a; din = d;
    tick();
    en_a = 1'b0; en_b = 1'b0; req = 1'b0; rdwr = 1'b0; addr = '0; din = '0;
  endtask

  // Called in the first cycle after acceptance; n is that cycle's index (1-based) on valid.
  task automatic wait_valid(input bit b, output int n, output bit oe_any, output int not_busy);
    n = 1; oe_any = 1'b0; not_busy = 0;
    while (!(b ? b_valid : a_valid) && n < 20) begin
      oe_any   |= (b ? b_oe : a_oe);
      not_busy += (b ? b_busy : a_busy) ? 0 : 1;
      tick();
      n++;
    end
    oe_any   |= (b ? b_oe : a_oe);
    not_busy += (b ? b_busy : a_busy) ? 0 : 1;
  endtask

  task automatic write_word(input bit b, input logic [31:0] a, input logic [31:0] d);
    int  n;
    bit  oe_any;
    int  nb;
    issue(b, 1'b1, a, d);
    wait_valid(b, n, oe_any, nb);
    chk("wr_oe_low", 32'(oe_any), 32'd0);
    tick();
  endtask

  initial begin
    int  n, nb, vcyc, cnt;
    bit  oe_any;
    reset = 1'b1; en_a = 0; en_b = 0; req = 0; rdwr = 0; addr = '0; din = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_oe", 32'(a_oe), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_dout", a_dout, 32'd0);
    chk("rst_b_dout", b_dout, 32'd0);

    // Single read of word 5
    write_word(0, 32'h14, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h14, 32'h0);
    chk("rd_busy_c1", 32'(a_busy), 32'd1);
    wait_valid(0, n, oe_any, nb);
    chk("rd_latency", 32'(n), 32'd4);
    chk("rd_busy_all", 32'(nb), 32'd0);
    chk("rd_oe", 32'(a_oe), 32'd1);
    chk("rd_data", a_dout, 32'hDEADBEEF);
    tick();
    chk("rd_pulse_end", 32'(a_valid), 32'd0);
    chk("rd_oe_end", 32'(a_oe), 32'd0);
    chk("rd_busy_end", 32'(a_busy), 32'd0);
    chk("rd_dout_hold", a_dout, 32'hDEADBEEF);

    // Write then read the same word in the next IDLE cycle
    issue(0, 1'b1, 32'h100, 32'hCAFEF00D);
    wait_valid(0, n, oe_any, nb);
    chk("wr_latency", 32'(n), 32'd4);
    chk("wr_oe_never", 32'(oe_any), 32'd0);
    tick();
    issue(0, 1'b0, 32'h100, 32'h0);
    wait_valid(0, n, oe_any, nb);
    chk("wr_rd_data", a_dout, 32'hCAFEF00D);

    // Line fill pair
    tick();
    write_word(0, 32'h40, 32'h11111111);
    write_word(0, 32'h44, 32'h22222222);
    issue(0, 1'b0, 32'h40, 32'h0);
    wait_valid(0, n, oe_any, nb);
    vcyc = cyc;
    chk("fill_d0", a_dout, 32'h11111111);
    tick();
    issue(0, 1'b0, 32'h44, 32'h0);
    wait_valid(0, n, oe_any, nb);
    chk("fill_gap", 32'(cyc - vcyc), 32'd5);
    chk("fill_d1", a_dout, 32'h22222222);
    tick();

    // Ignored traffic during WAIT/RESP and with mem_en low
    write_word(0, 32'h20, 32'hAAAA0001);
    write_word(0, 32'h24, 32'hBBBB0002);
    issue(0, 1'b0, 32'h20, 32'h0);
    en_a = 1'b1; req = 1'b1; addr = 32'h24; rdwr = 1'b1; din = 32'h0BAD0BAD;
    tick();
    en_a = 1'b0;
    tick();
    en_a = 1'b1; req = 1'b0;
    tick();
    chk("ign_valid", 32'(a_valid), 32'd1);
    chk("ign_data", a_dout, 32'hAAAA0001);
    req = 1'b1; rdwr = 1'b0;
    tick();
    chk("ign_resp_req", 32'(a_busy), 32'd0);
    en_a = 1'b0;
    tick();
    chk("ign_en_low", 32'(a_busy), 32'd0);
    tick();
    chk("ign_en_low2", 32'(a_busy | a_valid), 32'd0);
    req = 1'b0; addr = '0;
    tick();

    // Reset in the RESP cycle of a write
    write_word(0, 32'h8, 32'h0);
    issue(0, 1'b1, 32'h8, 32'h12345678);
    wait_valid(0, n, oe_any, nb);
    chk("rstw_latency", 32'(n), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_valid", 32'(a_valid), 32'd0);
    chk("rstw_oe", 32'(a_oe), 32'd0);
    chk("rstw_busy", 32'(a_busy), 32'd0);
    chk("rstw_dout", a_dout, 32'd0);
    issue(0, 1'b0, 32'h8, 32'h0);
    wait_valid(0, n, oe_any, nb);
    chk("rstw_array", a_dout, 32'd0);
    tick();

    // Reset during WAIT: no response follows
    issue(0, 1'b0, 32'h14, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstwait_busy", 32'(a_busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cnt += a_valid ? 1 : 0;
      tick();
    end
    chk("rstwait_novalid", 32'(cnt), 32'd0);

    // LATENCY=1 instance with address wrap and ignored low bits
    write_word(1, 32'h4, 32'h5A5A5A5A);
    issue(1, 1'b0, 32'h1004, 32'h0);
    wait_valid(1, n, oe_any, nb);
    chk("l1_latency", 32'(n), 32'd1);
    chk("l1_oe", 32'(b_oe), 32'd1);
    chk("l1_wrap_data", b_dout, 32'h5A5A5A5A);
    tick();
    chk("l1_pulse_end", 32'(b_valid), 32'd0);
    write_word(1, 32'h8, 32'h77770003);
    issue(1, 1'b0, 32'hFFFF_F00B, 32'h0);
    wait_valid(1, n, oe_any, nb);
    chk("l1_lowbits", b_dout, 32'h77770003);
    chk("l1_a_idle", 32'(a_busy), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Slave end of the 32-bit memory interconnect that the data and instruction caches master.
- Accepts one word request at a time from whichever initiator holds the bus. Serves it after a fixed, parameterised latency from an internal word array.
- Signals completion with a one-cycle mem_data_valid pulse.
- A 64-bit cache line fill is two back-to-back requests at addr and addr+4. The block has no knowledge of lines.

Parameters:
- ADDR_BITS, 10: word-address width; the array holds 2^ADDR_BITS 32-bit words.
- LATENCY, 4: cycles from request acceptance to the mem_data_valid pulse. Legal range 1 to 15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_en  in  1  bus held by an initiator; qualifies mem_req
- mem_req  in  1  request strobe, level-sensitive
- mem_addr  in  32  byte address; word index = mem_addr[ADDR_BITS+1:2]
- mem_rd_wr  in  1  0 = read, 1 = write
- mem_data_in  in  32  bus data as driven by the initiator (write data)
- mem_data_out  out  32  read data to bus tristate driver
- mem_data_oe  out  1  enable for bus tristate driver
- mem_data_valid  out  1  one-cycle completion pulse
- resp_busy  out  1  request in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: mem_data_valid=0, mem_data_oe=0, mem_data_out=0, resp_busy=0, state=IDLE, latency counter=0.
- Array contents are not cleared by reset.

States: IDLE, WAIT, RESP.

IDLE:
- Accept a request on the rising edge where mem_en=1 and mem_req=1.
- Latch the word index, mem_rd_wr, and mem_data_in into internal registers.
- Load the counter with LATENCY-1.
- Next state: RESP if LATENCY=1, otherwise WAIT.
- mem_req with mem_en=0 is ignored.

WAIT:
- resp_busy=1.
- Decrement the counter each cycle; go to RESP when the counter reaches 1.
- mem_req, mem_addr and mem_data_in are ignored; only the latched values are used.

RESP, exactly one cycle:
- mem_data_valid=1, resp_busy=1.
- Read: mem_data_oe=1 and mem_data_out=array[latched index], valid this cycle only.
- Write: array[latched index] is written with the latched data at the end of this cycle. mem_data_oe=0.
- Next state is always IDLE. A request present during RESP is not accepted.

Latency and throughput:
- Acceptance edge to mem_data_valid high is exactly LATENCY cycles.
- Back-to-back requests: a request can be accepted in the IDLE cycle immediately after RESP, so one word completes every LATENCY+1 cycles.

Output behaviour:
- mem_data_oe is never high outside a read RESP cycle. This prevents bus contention with initiators driving write data.
- mem_data_out holds its last value when oe=0.

Boundary conditions:
- Address mapping: mem_addr[1:0] is ignored (word aligned). Bits above ADDR_BITS+1 are ignored, so the address wraps modulo the array size.
- Write then read to the same word: the read, if accepted after the write's RESP, returns the new data.
- Reset asserted during WAIT or RESP: return to IDLE next edge with outputs at reset values.
  - A pending write is discarded, with no array update. This holds even when reset is asserted in the RESP cycle itself.
  - The reset cycle does not emit a mem_data_valid pulse.
- mem_en dropping mid-transaction does not abort it. The response still completes.

Test Plan:
- Single read, LATENCY=4, array[5] preloaded 32'hDEADBEEF:
  - Stimulus: mem_addr=32'h14, rd_wr=0, req on edge 0.
  - Required: valid and oe high on cycle 4 only, data_out=DEADBEEF; resp_busy high cycles 1-4.
- Write then read:
  - Stimulus: write 32'hCAFEF00D at 32'h100; when valid, issue a read of 32'h100 in the next IDLE cycle.
  - Required: read returns CAFEF00D; oe=0 throughout the write.
- Line-fill pair:
  - Stimulus: reads at 32'h40 then 32'h44 back-to-back.
  - Required: valid pulses exactly 5 cycles apart; data = array[16], array[17].
- Ignored traffic:
  - Stimulus: during WAIT, change addr, toggle req, drop mem_en; in IDLE, assert req with mem_en=0.
  - Required: first response uses the original latched address; no acceptance when mem_en=0.
- Reset mid-write:
  - Stimulus: write 32'h12345678 to 32'h8 with array[2]=0; assert reset in the RESP cycle.
  - Required: no valid pulse; array[2] still 0; all outputs 0 the following cycle.
- LATENCY=1 and wrap:
  - Stimulus: with ADDR_BITS=10, read 32'h1004.
  - Required: returns array[1], with valid on the cycle after acceptance.
